// File: rtl/usart_frame_seq.sv
// Bit-slot sequencer for multi-character USART frames: walks START/DATA/PARITY/STOP
// slots on each baud tick, with RTS gating only at character boundaries.
module usart_frame_seq #(
    parameter int MAX_CHARS = 4,
    parameter int CW        = $clog2(MAX_CHARS + 1),
    parameter int PW        = $clog2(MAX_CHARS * 12)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_en,
    input  logic          rts,
    input  logic [1:0]    cfg_dbits,
    input  logic          cfg_par,
    input  logic          cfg_stop2,
    input  logic [CW-1:0] num_chars,
    output logic          busy,
    output logic [1:0]    slot,
    output logic [2:0]    data_pos,
    output logic [CW-1:0] char_idx,
    output logic [PW-1:0] frame_pos,
    output logic          last,
    output logic          char_done,
    output logic          frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, HOLD} state_t;

    state_t        state_q, state_d;
    logic          start_pend_q, start_pend_d;
    logic [1:0]    dbits_q, dbits_d;
    logic          par_q, par_d;
    logic          stop2_q, stop2_d;
    logic [CW-1:0] nchars_q, nchars_d;
    logic [CW-1:0] char_idx_q, char_idx_d;
    logic [2:0]    data_pos_q, data_pos_d;
    logic [PW-1:0] frame_pos_q, frame_pos_d;
    logic          char_done_q, char_done_d;
    logic          frame_done_q, frame_done_d;

    logic          fin_stop, last_char, end_char;
    logic [CW-1:0] nchars_clamped;

    assign fin_stop       = (state_q == STOP2) || (state_q == STOP1 && !stop2_q);
    assign last_char      = (char_idx_q == nchars_q - CW'(1));
    assign end_char       = bit_en && fin_stop;
    assign nchars_clamped = (num_chars > CW'(MAX_CHARS)) ? CW'(MAX_CHARS) : num_chars;

    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q;
        dbits_d      = dbits_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        nchars_d     = nchars_q;
        char_idx_d   = char_idx_q;
        data_pos_d   = data_pos_q;
        frame_pos_d  = frame_pos_q;
        char_done_d  = 1'b0;
        frame_done_d = 1'b0;

        if (start && state_q == IDLE) start_pend_d = 1'b1;

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (start_pend_q && rts && num_chars != '0) begin
                        state_d      = START;
                        start_pend_d = 1'b0;
                        dbits_d      = cfg_dbits;
                        par_d        = cfg_par;
                        stop2_d      = cfg_stop2;
                        nchars_d     = nchars_clamped;
                        char_idx_d   = '0;
                        frame_pos_d  = '0;
                        data_pos_d   = '0;
                    end
                end
                START: begin
                    state_d     = DATA;
                    data_pos_d  = '0;
                    frame_pos_d = frame_pos_q + PW'(1);
                end
                DATA: begin
                    frame_pos_d = frame_pos_q + PW'(1);
                    if (data_pos_q == ({1'b0, dbits_q} + 3'd4)) begin
                        data_pos_d = '0;
                        state_d    = par_q ? PARITY : STOP1;
                    end else begin
                        data_pos_d = data_pos_q + 3'd1;
                    end
                end
                PARITY: begin
                    state_d     = STOP1;
                    frame_pos_d = frame_pos_q + PW'(1);
                end
                STOP1: begin
                    if (stop2_q) begin
                        state_d     = STOP2;
                        frame_pos_d = frame_pos_q + PW'(1);
                    end
                end
                HOLD: begin
                    if (rts) begin
                        state_d     = START;
                        char_idx_d  = char_idx_q + CW'(1);
                        frame_pos_d = frame_pos_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end

        // Leaving the final stop slot: a start seen on the frame's last tick is kept for the next frame.
        if (end_char) begin
            char_done_d = 1'b1;
            if (last_char) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
                char_idx_d   = '0;
                frame_pos_d  = '0;
                if (start) start_pend_d = 1'b1;
            end else if (rts) begin
                state_d     = START;
                char_idx_d  = char_idx_q + CW'(1);
                frame_pos_d = frame_pos_q + PW'(1);
            end else begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_pend_q <= 1'b0;
            dbits_q      <= '0;
            par_q        <= 1'b0;
            stop2_q      <= 1'b0;
            nchars_q     <= '0;
            char_idx_q   <= '0;
            data_pos_q   <= '0;
            frame_pos_q  <= '0;
            char_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            dbits_q      <= dbits_d;
            par_q        <= par_d;
            stop2_q      <= stop2_d;
            nchars_q     <= nchars_d;
            char_idx_q   <= char_idx_d;
            data_pos_q   <= data_pos_d;
            frame_pos_q  <= frame_pos_d;
            char_done_q  <= char_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        case (state_q)
            START:   slot = 2'd0;
            DATA:    slot = 2'd1;
            PARITY:  slot = 2'd2;
            default: slot = 2'd3;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign data_pos   = data_pos_q;
    assign char_idx   = char_idx_q;
    assign frame_pos  = frame_pos_q;
    assign last       = fin_stop && last_char;
    assign char_done  = char_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_usart_frame_seq.sv
// Self-checking bench for usart_frame_seq: a slot-index reference model
// (frame position k, char = k / L) is compared against every output each cycle.
module tb_usart_frame_seq;

    localparam int MAXC = 4;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(MAXC * 12);

    logic          clk = 1'b0;
    logic          rst, start, bit_en, rts;
    logic [1:0]    cfg_dbits;
    logic          cfg_par, cfg_stop2;
    logic [CW-1:0] num_chars;
    logic          busy, last, char_done, frame_done;
    logic [1:0]    slot;
    logic [2:0]    data_pos;
    logic [CW-1:0] char_idx;
    logic [PW-1:0] frame_pos;

    usart_frame_seq #(.MAX_CHARS(MAXC)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .rts(rts),
        .cfg_dbits(cfg_dbits), .cfg_par(cfg_par), .cfg_stop2(cfg_stop2),
        .num_chars(num_chars), .busy(busy), .slot(slot), .data_pos(data_pos),
        .char_idx(char_idx), .frame_pos(frame_pos), .last(last),
        .char_done(char_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_busy, m_hold, m_pend, m_cd, m_fd;
    int m_k, m_D, m_P, m_S2, m_N;

    // per-run observation counters
    int cd_cnt, fd_cnt, last_cnt, last_fp, fp9_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit st, input bit be, input bit r, input bit rs);
        int L;
        bit np;
        m_cd = 0;
        m_fd = 0;
        if (rs) begin
            m_busy = 0; m_hold = 0; m_pend = 0; m_k = 0;
            m_D = 5; m_P = 0; m_S2 = 0; m_N = 0;
            return;
        end
        np = m_pend | (st & !m_busy);
        if (be) begin
            if (!m_busy) begin
                if (m_pend && r && num_chars != 0) begin
                    m_busy = 1; m_hold = 0; m_k = 0;
                    m_D = int'(cfg_dbits) + 5; m_P = int'(cfg_par); m_S2 = int'(cfg_stop2);
                    m_N = (int'(num_chars) > MAXC) ? MAXC : int'(num_chars);
                    np = 0;
                end
            end else if (m_hold) begin
                if (r) begin m_hold = 0; m_k++; end
            end else begin
                L = 2 + m_D + m_P + m_S2;
                if (m_k % L == L - 1) begin
                    m_cd = 1;
                    if (m_k / L == m_N - 1) begin
                        m_fd = 1; m_busy = 0; m_k = 0;
                        if (st) np = 1;
                    end else if (r) m_k++;
                    else m_hold = 1;
                end else m_k++;
            end
        end
        m_pend = np;
    endtask

    task automatic step(input bit st, input bit be, input bit r, input bit rs);
        int L, p;
        int e_slot, e_dp, e_ci, e_fp;
        bit e_last;
        start = st; bit_en = be; rts = r; rst = rs;
        model(st, be, r, rs);
        @(posedge clk);
        #1;
        e_slot = 3; e_dp = 0; e_ci = 0; e_fp = 0; e_last = 0;
        if (m_busy) begin
            L    = 2 + m_D + m_P + m_S2;
            p    = m_k % L;
            e_ci = m_k / L;
            e_fp = m_k;
            if (!m_hold) begin
                if (p == 0) e_slot = 0;
                else if (p <= m_D) begin e_slot = 1; e_dp = p - 1; end
                else if (m_P != 0 && p == m_D + 1) e_slot = 2;
                e_last = (p == L - 1) && (e_ci == m_N - 1);
            end
        end
        chk("busy", busy, m_busy);
        chk("slot", slot, e_slot);
        chk("data_pos", data_pos, e_dp);
        chk("char_idx", char_idx, e_ci);
        chk("frame_pos", frame_pos, e_fp);
        chk("last", last, e_last);
        chk("char_done", char_done, m_cd);
        chk("frame_done", frame_done, m_fd);
        if (char_done === 1'b1) cd_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (last === 1'b1) begin last_cnt++; last_fp = int'(frame_pos); end
        if (busy === 1'b1 && frame_pos == PW'(9)) fp9_cnt++;
    endtask

    // Runs until the DUT reports frame_done or the cycle budget runs out.
    task automatic run(input int period, input int budget, input int rts_lo, input int rts_hi,
                       input bit rand_rts, input int st_c, input bit rand_st);
        bit got_fd, st, be, r;
        got_fd = 0;
        cd_cnt = 0; fd_cnt = 0; last_cnt = 0; last_fp = -1; fp9_cnt = 0;
        for (int c = 0; c < budget; c++) begin
            st = (c == st_c) || (rand_st && $urandom_range(0, 15) == 0);
            be = (c % period == 0);
            if (c >= rts_lo && c < rts_hi) r = 0;
            else r = rand_rts ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(st, be, r, 0);
            if (frame_done === 1'b1) begin got_fd = 1; break; end
        end
        chk("frame_timeout", got_fd, 1);
    endtask

    task automatic set_cfg(input int db, input bit par, input bit s2, input int n);
        cfg_dbits = 2'(db); cfg_par = par; cfg_stop2 = s2; num_chars = CW'(n);
    endtask

    initial begin
        rst = 1; start = 0; bit_en = 0; rts = 0;
        set_cfg(0, 0, 0, 0);

        // reset, including a start coinciding with rst that must be dropped
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);
        chk("reset_slot", slot, 3);
        set_cfg(3, 0, 0, 4);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("rst_start_dropped", busy, 0);

        // 8N1, 4 chars, tick every cycle
        run(1, 200, -1, -1, 0, 0, 0);
        chk("8n1_char_done_cnt", cd_cnt, 4);
        chk("8n1_frame_done_cnt", fd_cnt, 1);
        chk("8n1_last_fp", last_fp, 39);
        chk("8n1_last_cnt", last_cnt, 1);

        // 7E2, 2 chars, tick every 4th cycle
        step(0, 0, 0, 1);
        set_cfg(2, 1, 1, 2);
        run(4, 400, -1, -1, 0, 0, 0);
        chk("7e2_last_fp", last_fp, 21);
        chk("7e2_char_done_cnt", cd_cnt, 2);
        chk("7e2_last_cnt", last_cnt, 4);

        // rts dropped mid char0: no stall inside the character, HOLD afterwards
        step(0, 0, 0, 1);
        set_cfg(3, 0, 0, 2);
        run(1, 200, 5, 15, 0, 0, 0);
        chk("hold_fp9_cycles", fp9_cnt, 5);
        chk("hold_last_fp", last_fp, 19);
        chk("hold_char_done_cnt", cd_cnt, 2);

        // start on a non-tick cycle is captured; a start while busy is ignored
        step(0, 0, 0, 1);
        set_cfg(0, 0, 0, 1);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("pend_wait_busy", busy, 0);
        run(3, 300, -1, -1, 0, 9, 0);
        chk("pend_frame_done_cnt", fd_cnt, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        chk("busy_start_ignored", busy, 0);

        // reset mid-frame at frame_pos 17
        step(0, 0, 0, 1);
        set_cfg(3, 0, 0, 4);
        step(1, 1, 1, 0);
        for (int i = 0; i < 60; i++) begin
            step(0, 1, 1, 0);
            if (m_busy && m_k == 17) break;
        end
        chk("pre_rst_fp", frame_pos, 17);
        step(0, 1, 1, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_slot", slot, 3);
        chk("midrst_fp", frame_pos, 0);
        chk("midrst_done", {char_done, frame_done}, 0);

        // num_chars=0 never begins; then 6 clamps to MAX_CHARS
        set_cfg(3, 0, 0, 0);
        step(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        chk("nchars0_busy", busy, 0);
        num_chars = CW'(6);
        run(1, 200, -1, -1, 0, -1, 0);
        chk("clamp_char_done_cnt", cd_cnt, 4);
        chk("clamp_last_fp", last_fp, 39);

        // randomized frames
        for (int it = 0; it < 10; it++) begin
            step(0, 0, 0, 1);
            set_cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 6));
            run($urandom_range(1, 3), 2000, -1, -1, 1, 0, 1);
            chk("rnd_char_done_cnt", cd_cnt, m_N);
            chk("rnd_last_fp", last_fp, m_N * (2 + m_D + m_P + m_S2) - 1);
            for (int i = 0; i < 6; i++) step(0, $urandom_range(0, 1), 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usart_frame_seq.md
Name: usart_frame_seq

Overview:
- Parametrised bit-slot sequencer for the USART transmit/receive path. Successor to the fixed 40-slot frame counter.
- Steps through a multi-character frame, one slot per baud tick (bit_en). Runtime-configurable: data bits (5-8), parity on/off, 1 or 2 stop bits, characters per frame.
- Reports slot type, data bit position, character index and overall frame position to the shift/parity logic.
- RTS flow control gates only character boundaries, never mid-character.

Parameters:
- MAX_CHARS, 4, maximum characters per frame.
- CW, $clog2(MAX_CHARS+1), width of num_chars and char_idx.
- PW, $clog2(MAX_CHARS*12), width of frame_pos.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle or level request to begin a frame.
- bit_en  in  1  baud tick; the sequencer advances only on cycles where bit_en=1.
- rts  in  1  flow control; 1 = peer ready.
- cfg_dbits  in  2  data bits minus 5 (0=5 … 3=8).
- cfg_par  in  1  parity slot enable.
- cfg_stop2  in  1  two stop bits.
- num_chars  in  CW  characters per frame.
- busy  out  1  frame in progress (any state but IDLE).
- slot  out  2  0=START, 1=DATA, 2=PARITY, 3=STOP; 3 also while in IDLE or HOLD (line mark).
- data_pos  out  3  data bit index (LSB first) while slot=DATA; 0 otherwise.
- char_idx  out  CW  current character index.
- frame_pos  out  PW  slot count since the frame's first START slot; HOLD slots are not counted.
- last  out  1  high throughout the final stop slot of the final character.
- char_done  out  1  one-cycle pulse when a character's final stop slot ends.
- frame_done  out  1  one-cycle pulse when the frame ends.

Behaviour:
- Reset values: all outputs 0 except slot=3. start_pend cleared. Config registers cleared (cfg_dbits=0, cfg_par=0, cfg_stop2=0, num_chars=0).
- Reset mid-frame: returns to IDLE on the next edge with no done pulses. A start asserted in the same cycle as rst is dropped.
- start_pend:
  - Set by start=1 while in IDLE.
  - Cleared when the frame begins.
  - start while busy is ignored, not queued.
  - If start=1 in the same cycle the frame ends, the request is captured and the next frame may begin on a later tick.
- Config latch: cfg_dbits, cfg_par, cfg_stop2 and num_chars are registered on the tick that leaves IDLE. Changes during a frame have no effect.
- num_chars handling:
  - 0: start_pend is held but the frame never begins while 0.
  - > MAX_CHARS: clamped to MAX_CHARS.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, HOLD. Every transition requires bit_en=1. Without bit_en, all state and outputs hold.
- Transitions (each on a tick):
  - IDLE -> START when start_pend & rts & num_chars!=0; char_idx=0, frame_pos=0.
  - START -> DATA, data_pos=0.
  - DATA with data_pos < D-1 -> DATA, data_pos+1. D = cfg_dbits+5.
  - DATA at data_pos = D-1 -> PARITY if cfg_par, else STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if cfg_stop2, else end-of-char.
  - STOP2 -> end-of-char.
- End-of-char (on the tick leaving the final stop slot):
  - char_done=1.
  - Final character (char_idx = N-1): frame_done=1, go to IDLE.
  - Otherwise, rts=1: go to START with char_idx+1.
  - Otherwise, rts=0: go to HOLD.
- HOLD -> START, char_idx+1, on a tick with rts=1. rts=0 mid-character does not stall.
- frame_pos increments by 1 on each counted slot transition and is 0 in IDLE. Final value = N*(2+D+P+S2)-1, where P = cfg_par and S2 = cfg_stop2. Example: 8N1 with 4 characters ends at 39.
- last is combinational from state: final stop slot and char_idx = N-1.

Test Plan:
- 8N1, num_chars=4, rts=1, bit_en every cycle, start pulse -> 40 slots. frame_pos runs 0..39. slot for char0 = 0,1×8,3. last high at frame_pos 39. frame_done pulses once. Four char_done pulses.
- 7E2 (cfg_dbits=2, par=1, stop2=1), num_chars=2, bit_en every 4th cycle -> per char: START, DATA 0-6, PARITY, STOP, STOP (11 slots). Final frame_pos=21. Outputs stable between ticks.
- 8N1, rts dropped during char0 DATA slot 3 -> no stall inside char0. HOLD after char0 STOP: slot=3, frame_pos frozen at 9. rts=1 -> START of char1 on the next tick, frame_pos=10.
- start pulse on a non-tick cycle -> captured. Frame begins at the next tick. Second start during the frame -> ignored; IDLE after frame_done.
- rst asserted at frame_pos 17 -> next edge: busy=0, slot=3, frame_pos=0, no char_done/frame_done.
- num_chars=0 with start -> busy stays 0. Change num_chars to 6 with MAX_CHARS=4 -> frame of exactly 4 characters.
